sym_packer: RTL

- Consumer stage placed directly downstream of the team's 2-bit FIFO.
- Drains the FIFO's first-word-fall-through output one symbol per pop and packs SYMS symbols, LSB-first, into one wide word.
- Presents the packed word on a valid/ready output handshake.
- A flush input emits a partially filled word together with a symbol count.

---
 rtl/sym_packer_if.sv | 29 ++
 rtl/sym_packer.sv | 98 +++++++++
 2 files changed

// File: rtl/sym_packer_if.sv
// Handshake bundle around sym_packer: the FIFO drain side (head symbol,
// empty flag, pop strobe, flush request) and the packed-word output side
// (data, symbol count, valid/ready).
interface sym_packer_if #(
  parameter int W    = 2,
  parameter int SYMS = 4,
  parameter int CW   = 3
);
  logic [W-1:0]      io_fifo_dout;
  logic              io_fifo_empty;
  logic              io_fifo_pop;
  logic              io_flush;
  logic [W*SYMS-1:0] io_out_data;
  logic [CW-1:0]     io_out_count;
  logic              io_out_valid;
  logic              io_out_ready;

  // Packer's own view.
  modport master (
    input  io_fifo_dout, io_fifo_empty, io_flush, io_out_ready,
    output io_fifo_pop, io_out_data, io_out_count, io_out_valid
  );

  // Surrounding logic: upstream FIFO, flush source and downstream consumer.
  modport slave (
    output io_fifo_dout, io_fifo_empty, io_flush, io_out_ready,
    input  io_fifo_pop, io_out_data, io_out_count, io_out_valid
  );
endinterface

// File: rtl/sym_packer.sv
// Symbol packer: drains a first-word-fall-through FIFO one symbol per pop,
// packs SYMS symbols LSB-first into a word and holds it on a valid/ready
// output. A flush emits a partial word with its symbol count; slots not
// filled read as zero.
module sym_packer #(
  parameter int W    = 2,
  parameter int SYMS = 4,
  parameter int CW   = 3
) (
  input  logic         clk,
  input  logic         reset,
  sym_packer_if.master bus
);

  localparam int IW = $clog2(SYMS);
  localparam int DW = W * SYMS;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [DW-1:0]  data_q, data_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  fill_cnt;
  logic           pop;

  // State register; reset abandons any held word without a handshake.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  // Slot index, packed data and symbol count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      idx_q   <= idx_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // Next-state, datapath update and pop decode.
  always_comb begin
    // NOTE: every target gets a default first so no path infers a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    count_d  = count_q;
    pop      = 1'b0;
    fill_cnt = CW'(idx_q);

    unique case (state_q)
      FILL: begin
        pop      = ~bus.io_fifo_empty & ~reset;
        fill_cnt = CW'(idx_q) + CW'(pop);
        if (pop) begin
          for (int i = 0; i < SYMS; i++) begin
            if (idx_q == IW'(i)) data_d[i*W +: W] = bus.io_fifo_dout;
          end
          idx_d = idx_q + IW'(1);
        end
        if (pop && idx_q == IW'(SYMS - 1)) begin
          state_d = HOLD;
          count_d = CW'(SYMS);
          idx_d   = '0;
        end else if (bus.io_flush && fill_cnt != '0) begin
          // A symbol popped alongside the flush is part of this word.
          state_d = HOLD;
          count_d = fill_cnt;
          idx_d   = '0;
        end
      end
      HOLD: begin
        if (bus.io_out_ready) begin
          state_d = FILL;
          data_d  = '0;
          count_d = '0;
          idx_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign bus.io_fifo_pop  = pop;
  assign bus.io_out_data  = data_q;
  assign bus.io_out_count = count_q;
  assign bus.io_out_valid = (state_q == HOLD);

endmodule
